exe: RTL

//  Execute stage of the bexkat1 pipeline, directly upstream of the memory stage.

---
 rtl/exe.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/exe.sv
// ---------------------------------------------------------------------------
// exe -- execute stage of the bexkat1 pipeline (feeds the memory stage)
//
// Computes ALU results, load/store effective addresses, stack pointer
// adjustments and branch/jump targets. Holds the {Z,N,C,V} condition flags
// and runs an iterative 32-step multiply/divide unit for T_INTU ops.
// One registered instruction per cycle is presented to mem, or a bubble
// (ir_o = 0) while the multiply/divide unit owns the stage.
//
// Ports
//   clk_i, rst_i         clock, synchronous active-high reset
//   stall_i              mem stall: every output register holds
//   stall_o              upstream must hold ir_i/pc_i/operands
//   ir_i, pc_i           instruction ([31:28] type, [27:24] op, [0] size,
//                        [63:32] imm) and its PC
//   reg_data1_i/2_i      operands A and B
//   sp_data_i            current stack pointer
//   exc_i                exception request tagged to ir_i
//   ir_o ... exc_o       registered results for the memory stage
// ---------------------------------------------------------------------------
module exe #(
    parameter logic [31:0] VECTOR_BASE = 32'hFFFFFFE0,
    parameter bit          MD_ENABLE   = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    output logic        stall_o,
    input  logic [63:0] ir_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] reg_data1_i,
    input  logic [31:0] reg_data2_i,
    input  logic [31:0] sp_data_i,
    input  logic        exc_i,
    output logic [63:0] ir_o,
    output logic [31:0] pc_o,
    output logic        pc_set_o,
    output logic [31:0] result_o,
    output logic [31:0] reg_data1_o,
    output logic [31:0] reg_data2_o,
    output logic [31:0] sp_data_o,
    output logic [1:0]  sp_write_o,
    output logic        exc_o
);

    localparam logic [3:0] T_INH    = 4'h0;
    localparam logic [3:0] T_PUSH   = 4'h1;
    localparam logic [3:0] T_POP    = 4'h2;
    localparam logic [3:0] T_CMP    = 4'h3;
    localparam logic [3:0] T_INTU   = 4'h5;
    localparam logic [3:0] T_INT    = 4'h6;
    localparam logic [3:0] T_LOAD   = 4'h9;
    localparam logic [3:0] T_STORE  = 4'ha;
    localparam logic [3:0] T_BRANCH = 4'hb;
    localparam logic [3:0] T_JUMP   = 4'hc;

    logic [3:0]  ir_type;
    logic [3:0]  ir_op;
    logic        ir_size;
    logic [31:0] imm;
    logic [31:0] alu_b;
    logic        unused_ir_bits;

    assign ir_type        = ir_i[31:28];
    assign ir_op          = ir_i[27:24];
    assign ir_size        = ir_i[0];
    assign imm            = ir_i[63:32];
    assign alu_b          = ir_size ? imm : reg_data2_i;
    assign unused_ir_bits = ^ir_i[23:1];

    // Condition flags
    logic        flag_z, flag_n, flag_c, flag_v;
    logic [32:0] cmp_diff;
    logic        br_taken;

    // Multiply/divide unit
    logic        md_busy, md_done;
    logic [4:0]  md_count;
    logic [1:0]  md_op;
    logic [31:0] md_a;     // multiplier (shifts right) / dividend -> quotient
    logic [31:0] md_b;     // multiplicand (shifts left) / divisor
    logic [31:0] md_acc;   // product / partial remainder
    logic [32:0] div_shift;
    logic        div_ge;
    logic [31:0] md_result;
    logic        md_req, md_start, load_en;

    // Only ops 0-2 are real multiply/divide work; others fall through as 0.
    assign md_req    = MD_ENABLE && (ir_type == T_INTU) && (ir_op <= 4'd2) && !exc_i;
    assign md_start  = md_req && !md_busy && !md_done && !stall_i;
    assign stall_o   = md_start | md_busy;
    assign load_en   = !stall_i && !md_start && !md_busy;

    assign div_shift = {md_acc, md_a[31]};
    assign div_ge    = div_shift >= {1'b0, md_b};
    assign md_result = (md_op == 2'd1) ? md_a : md_acc;

    assign cmp_diff  = {1'b0, reg_data1_i} - {1'b0, reg_data2_i};

    always_comb begin
        br_taken = 1'b0;
        case (ir_op)
            4'd0:    br_taken = 1'b1;
            4'd1:    br_taken = flag_z;
            4'd2:    br_taken = !flag_z;
            4'd3:    br_taken = !flag_c && !flag_z;
            4'd4:    br_taken = !flag_c;
            4'd5:    br_taken = flag_c;
            4'd6:    br_taken = flag_n ^ flag_v;
            4'd7:    br_taken = !(flag_n ^ flag_v);
            default: br_taken = 1'b0;
        endcase
    end

    logic [31:0] nxt_result, nxt_pc, nxt_rd1, nxt_sp;
    logic        nxt_pc_set;
    logic [1:0]  nxt_sp_write;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        nxt_result   = '0;
        nxt_pc       = pc_i;
        nxt_pc_set   = 1'b0;
        nxt_rd1      = reg_data1_i;
        nxt_sp       = sp_data_i;
        nxt_sp_write = 2'b00;
        if (exc_i) begin
            nxt_result = VECTOR_BASE;
            nxt_sp     = sp_data_i - 32'd4;
        end else begin
            case (ir_type)
                T_INH: if (ir_op == 4'd5) begin
                    nxt_result = VECTOR_BASE + {27'd0, imm[1:0], 3'b000};
                    nxt_sp     = sp_data_i - 32'd4;
                end
                T_INT: case (ir_op)
                    4'd0:    nxt_result = reg_data1_i + alu_b;
                    4'd1:    nxt_result = reg_data1_i - alu_b;
                    4'd2:    nxt_result = reg_data1_i & alu_b;
                    4'd3:    nxt_result = reg_data1_i | alu_b;
                    4'd4:    nxt_result = reg_data1_i ^ alu_b;
                    4'd5:    nxt_result = reg_data1_i << alu_b[4:0];
                    4'd6:    nxt_result = reg_data1_i >> alu_b[4:0];
                    4'd7:    nxt_result = $signed(reg_data1_i) >>> alu_b[4:0];
                    4'd8:    nxt_result = alu_b;
                    default: nxt_result = '0;
                endcase
                T_LOAD, T_STORE: nxt_result = reg_data2_i + imm;
                T_PUSH: begin
                    nxt_sp       = sp_data_i - 32'd4;
                    nxt_sp_write = 2'b01;
                    if (ir_op != 4'd0) nxt_result = imm;   // JSR: target rides on result
                end
                T_POP: begin
                    nxt_rd1      = sp_data_i;
                    nxt_sp       = sp_data_i + 32'd4;
                    nxt_sp_write = 2'b01;
                end
                T_BRANCH: if (br_taken) begin
                    nxt_pc     = pc_i + imm;
                    nxt_pc_set = 1'b1;
                end
                T_JUMP: begin
                    nxt_pc     = imm;
                    nxt_pc_set = 1'b1;
                end
                T_INTU: if (md_done) nxt_result = md_result;
                default: ;
            endcase
        end
    end

    // Output register
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state is always assigned with <= so every register samples pre-edge values.
        if (rst_i) begin
            ir_o        <= '0;
            pc_o        <= '0;
            pc_set_o    <= 1'b0;
            result_o    <= '0;
            reg_data1_o <= '0;
            reg_data2_o <= '0;
            sp_data_o   <= '0;
            sp_write_o  <= 2'b00;
            exc_o       <= 1'b0;
        end else if (!stall_i) begin
            if (md_start || md_busy) begin
                ir_o       <= '0;
                pc_set_o   <= 1'b0;
                sp_write_o <= 2'b00;
                exc_o      <= 1'b0;
            end else begin
                ir_o        <= ir_i;
                pc_o        <= nxt_pc;
                pc_set_o    <= nxt_pc_set;
                result_o    <= nxt_result;
                reg_data1_o <= nxt_rd1;
                reg_data2_o <= reg_data2_i;
                sp_data_o   <= nxt_sp;
                sp_write_o  <= nxt_sp_write;
                exc_o       <= exc_i;
            end
        end
    end

    // Flags change only when a CMP is actually registered into mem.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            {flag_z, flag_n, flag_c, flag_v} <= 4'b0000;
        end else if (load_en && !exc_i && ir_type == T_CMP) begin
            flag_z <= (cmp_diff[31:0] == 32'd0);
            flag_n <= cmp_diff[31];
            flag_c <= cmp_diff[32];
            flag_v <= (reg_data1_i[31] ^ reg_data2_i[31]) & (reg_data1_i[31] ^ cmp_diff[31]);
        end
    end

    // Multiply/divide control: iterations run regardless of stall_i, the
    // finished result waits in done until mem accepts it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            md_busy  <= 1'b0;
            md_done  <= 1'b0;
            md_count <= '0;
        end else if (md_start) begin
            md_busy  <= 1'b1;
            md_count <= '0;
        end else if (md_busy) begin
            md_count <= md_count + 5'd1;
            if (md_count == 5'd31) begin
                md_busy <= 1'b0;
                md_done <= 1'b1;
            end
        end else if (md_done && !stall_i) begin
            md_done <= 1'b0;
        end
    end

    // NOTE: the datapath registers are always loaded on start before they are read, so they carry no reset.
    always_ff @(posedge clk_i) begin
        if (md_start) begin
            md_op  <= ir_op[1:0];
            md_a   <= reg_data1_i;
            md_b   <= alu_b;
            md_acc <= '0;
        end else if (md_busy) begin
            if (md_op == 2'd0) begin
                if (md_a[0]) md_acc <= md_acc + md_b;
                md_a <= md_a >> 1;
                md_b <= md_b << 1;
            end else begin
                // Restoring divide; a zero divisor always "fits", giving
                // all-ones quotient and remainder = dividend.
                md_acc <= div_ge ? (div_shift[31:0] - md_b) : div_shift[31:0];
                md_a   <= {md_a[30:0], div_ge};
            end
        end
    end

endmodule
